// File: rtl/tick_gen_multi.sv
// tick_gen_multi
//   Multi-channel programmable tick / clock-enable generator. Every channel
//   divides clk by its own runtime-programmable divisor. It produces a
//   one-cycle tick strobe per period and a 50 % square wave with a period of
//   2 x divisor. A new divisor is staged in a shadow register and only becomes
//   active at the channel's next terminal count, so no period is ever cut
//   short.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   div_wr    in   divisor write strobe (one cycle)
//   div_sel   in   channel addressed by div_wr; values >= CHANNELS are ignored
//   div_data  in   new divisor, period in clk cycles (0 behaves as 1)
//   sync_clr  in   synchronous restart of all channels
//   tick      out  per-channel one-cycle strobe (held high when divisor is 1)
//   sq        out  per-channel square wave, toggles with every tick
//   wr_pend   out  per-channel flag: shadow divisor loaded, not yet active
module tick_gen_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 26,
    parameter int SEL_W       = 2,
    parameter int DEFAULT_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [CNT_W-1:0]    div_data,
    input  logic                sync_clr,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq,
    output logic [CHANNELS-1:0] wr_pend
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_nxt;
            logic [CNT_W-1:0] div_act;
            logic [CNT_W-1:0] act_nxt;
            logic [CNT_W-1:0] div_shd;
            logic [CNT_W-1:0] shd_nxt;
            logic [CNT_W-1:0] eff;
            logic             pend;
            logic             pend_nxt;
            logic             tick_q;
            logic             tick_nxt;
            logic             sq_q;
            logic             sq_nxt;
            logic             wr_hit;
            logic             term;

            // Zero-extending compare: a select beyond the channel count
            // matches no channel, so such writes are dropped.
            assign wr_hit = div_wr && (int'(div_sel) == g);

            // A divisor of 0 runs at the fastest rate, same as 1.
            assign eff  = (div_act == '0) ? ONE : div_act;

            // The counter never exceeds eff-1: the active divisor only changes
            // when cnt is 0 (swap at terminal count or restart).
            assign term = (cnt == (eff - ONE));

            always_comb begin
                cnt_nxt  = cnt;
                act_nxt  = div_act;
                shd_nxt  = div_shd;
                pend_nxt = pend;
                tick_nxt = tick_q;
                sq_nxt   = sq_q;

                if (sync_clr) begin
                    cnt_nxt  = '0;
                    tick_nxt = 1'b0;
                    sq_nxt   = 1'b0;
                    pend_nxt = 1'b0;
                    // A write coinciding with the restart bypasses the shadow
                    // and becomes active immediately.
                    if (wr_hit) begin
                        act_nxt = div_data;
                        shd_nxt = div_data;
                    end else begin
                        act_nxt = div_shd;
                    end
                end else begin
                    if (term) begin
                        cnt_nxt  = '0;
                        tick_nxt = 1'b1;
                        sq_nxt   = ~sq_q;
                        if (pend) begin
                            act_nxt  = div_shd;
                            pend_nxt = 1'b0;
                        end
                    end else begin
                        cnt_nxt  = cnt + ONE;
                        tick_nxt = 1'b0;
                    end

                    // Evaluated after the swap so that a write landing on the
                    // terminal edge keeps pend set; the swap above already took
                    // the old shadow value.
                    if (wr_hit) begin
                        shd_nxt  = div_data;
                        pend_nxt = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt     <= '0;
                    div_act <= DIV_RST;
                    div_shd <= DIV_RST;
                    pend    <= 1'b0;
                    tick_q  <= 1'b0;
                    sq_q    <= 1'b0;
                end else begin
                    cnt     <= cnt_nxt;
                    div_act <= act_nxt;
                    div_shd <= shd_nxt;
                    pend    <= pend_nxt;
                    tick_q  <= tick_nxt;
                    sq_q    <= sq_nxt;
                end
            end

            assign tick[g]    = tick_q;
            assign sq[g]      = sq_q;
            assign wr_pend[g] = pend;
        end
    endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;

    logic       clk;
    logic       reset;
    logic       div_wr;
    logic [1:0] div_sel;
    logic [7:0] div_data;
    logic       sync_clr;
    logic [3:0] tick;
    logic [3:0] sq;
    logic [3:0] wr_pend;
    logic [2:0] tick3;
    logic [2:0] sq3;
    logic [2:0] wr_pend3;

    int n_checks = 0;
    int n_fail   = 0;

    tick_gen_multi #(
        .CHANNELS(4), .CNT_W(8), .SEL_W(2), .DEFAULT_DIV(5)
    ) dut (
        .clk(clk), .reset(reset), .div_wr(div_wr), .div_sel(div_sel),
        .div_data(div_data), .sync_clr(sync_clr),
        .tick(tick), .sq(sq), .wr_pend(wr_pend)
    );

    // Three-channel build sharing the same stimulus, for out-of-range selects.
    tick_gen_multi #(
        .CHANNELS(3), .CNT_W(8), .SEL_W(2), .DEFAULT_DIV(5)
    ) dut3 (
        .clk(clk), .reset(reset), .div_wr(div_wr), .div_sel(div_sel),
        .div_data(div_data), .sync_clr(sync_clr),
        .tick(tick3), .sq(sq3), .wr_pend(wr_pend3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;   // fresh reset before this vector; edge count restarts at 1
        logic       wr;
        logic [1:0] sel;
        logic [7:0] data;
        logic       clr;
        logic [3:0] tick;
        logic [3:0] sq;
        logic [3:0] pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic wr, input logic [1:0] sel,
                       input logic [7:0] data, input logic clr,
                       input logic [3:0] t, input logic [3:0] s, input logic [3:0] p);
        vec_t v;
        v.rst = rst; v.wr = wr; v.sel = sel; v.data = data; v.clr = clr;
        v.tick = t; v.sq = s; v.pend = p;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        div_wr   = 1'b0;
        div_sel  = 2'd0;
        div_data = 8'd0;
        sync_clr = 1'b0;
    endtask

    // Leaves the bench at a falling edge with reset released; the next
    // rising edge is edge 1.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        // Reset defaults: divisor 5 on every channel, 20 edges.
        for (int k = 1; k <= 20; k++)
            add(k == 1, 0, 0, 0, 0,
                (k % 5 == 0) ? 4'hF : 4'h0,
                ((k / 5) % 2 == 1) ? 4'hF : 4'h0,
                4'h0);

        // Glitch-free reprogram: divisor 3 to channel 1 at edge 2.
        add(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 1
        add(0, 1, 1, 3, 0, 4'b0000, 4'b0000, 4'b0010); // 2
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0010); // 3
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0010); // 4
        add(0, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000); // 5
        add(0, 0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000); // 6
        add(0, 0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000); // 7
        add(0, 0, 0, 0, 0, 4'b0010, 4'b1101, 4'b0000); // 8
        add(0, 0, 0, 0, 0, 4'b0000, 4'b1101, 4'b0000); // 9
        add(0, 0, 0, 0, 0, 4'b1101, 4'b0000, 4'b0000); // 10
        add(0, 0, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000); // 11
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000); // 12
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000); // 13
        add(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000); // 14
        add(0, 0, 0, 0, 0, 4'b1101, 4'b1101, 4'b0000); // 15

        // Divisor 0 on channel 2, then sync_clr.
        add(1, 1, 2, 0, 0, 4'b0000, 4'b0000, 4'b0100); // 1
        add(0, 0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000); // 2 clear
        add(0, 0, 0, 0, 0, 4'b0100, 4'b0100, 4'b0000); // 3
        add(0, 0, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000); // 4
        add(0, 0, 0, 0, 0, 4'b0100, 4'b0100, 4'b0000); // 5
        add(0, 0, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000); // 6
        add(0, 0, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000); // 7
        add(0, 0, 0, 0, 0, 4'b0100, 4'b1011, 4'b0000); // 8

        // sync_clr at edge 3 together with divisor 2 to channel 0.
        add(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 1
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 2
        add(0, 1, 0, 2, 1, 4'b0000, 4'b0000, 4'b0000); // 3 clear + write
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 4
        add(0, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000); // 5
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000); // 6
        add(0, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000); // 7
        add(0, 0, 0, 0, 0, 4'b1110, 4'b1110, 4'b0000); // 8
        add(0, 0, 0, 0, 0, 4'b0001, 4'b1111, 4'b0000); // 9
        add(0, 0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000); // 10

        // Write collision on channel 3's terminal edge.
        add(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 1
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 2
        add(0, 1, 3, 4, 0, 4'b0000, 4'b0000, 4'b1000); // 3
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1000); // 4
        add(0, 1, 3, 7, 0, 4'b1111, 4'b1111, 4'b1000); // 5 terminal + write
        add(0, 0, 0, 0, 0, 4'b0000, 4'b1111, 4'b1000); // 6
        add(0, 0, 0, 0, 0, 4'b0000, 4'b1111, 4'b1000); // 7
        add(0, 0, 0, 0, 0, 4'b0000, 4'b1111, 4'b1000); // 8
        add(0, 0, 0, 0, 0, 4'b1000, 4'b0111, 4'b0000); // 9
        add(0, 0, 0, 0, 0, 4'b0111, 4'b0000, 4'b0000); // 10
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 11
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 12
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 13
        add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000); // 14
        add(0, 0, 0, 0, 0, 4'b0111, 4'b0111, 4'b0000); // 15
        add(0, 0, 0, 0, 0, 4'b1000, 4'b1111, 4'b0000); // 16

        // Outputs during reset.
        #3;
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_sq",   32'(sq),   32'h0);
        chk("reset_pend", 32'(wr_pend), 32'h0);

        begin
            int edge_n;
            edge_n = 0;
            foreach (vecs[i]) begin
                if (vecs[i].rst) begin
                    do_reset();
                    edge_n = 0;
                end
                div_wr   = vecs[i].wr;
                div_sel  = vecs[i].sel;
                div_data = vecs[i].data;
                sync_clr = vecs[i].clr;
                step();
                edge_n++;
                chk($sformatf("v%0d_e%0d_tick", i, edge_n), 32'(tick),    32'(vecs[i].tick));
                chk($sformatf("v%0d_e%0d_sq",   i, edge_n), 32'(sq),      32'(vecs[i].sq));
                chk($sformatf("v%0d_e%0d_pend", i, edge_n), 32'(wr_pend), 32'(vecs[i].pend));
            end
            idle_inputs();
        end

        // Reset asserted mid-period at cycle 7 clears outputs without a clock edge.
        do_reset();
        repeat (7) step();
        chk("mid_pre_sq", 32'(sq), 32'hF);
        div_wr = 1'b1; div_sel = 2'd1; div_data = 8'd2;
        step();
        idle_inputs();
        chk("mid_pre_pend", 32'(wr_pend), 32'h2);
        reset = 1'b0;
        #1;
        chk("mid_rst_tick", 32'(tick),    32'h0);
        chk("mid_rst_sq",   32'(sq),      32'h0);
        chk("mid_rst_pend", 32'(wr_pend), 32'h0);
        // Pending write is lost: channel 1 runs on the default period of 5.
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step();
        chk("post_rst_e4_tick", 32'(tick), 32'h0);
        step();
        chk("post_rst_e5_tick", 32'(tick), 32'hF);
        chk("post_rst_e5_pend", 32'(wr_pend), 32'h0);

        // Select 3 on the three-channel build is ignored; on four channels it is valid.
        do_reset();
        div_wr = 1'b1; div_sel = 2'd3; div_data = 8'd2;
        step();
        idle_inputs();
        chk("sel3_c3_pend", 32'(wr_pend3), 32'h0);
        chk("sel3_c4_pend", 32'(wr_pend),  32'h8);
        repeat (3) step();
        chk("sel3_c3_e4_tick", 32'(tick3), 32'h0);
        step();
        chk("sel3_c3_e5_tick", 32'(tick3), 32'h7);
        chk("sel3_c3_e5_sq",   32'(sq3),   32'h7);
        chk("sel3_c3_e5_pend", 32'(wr_pend3), 32'h0);
        chk("sel3_c4_e5_pend", 32'(wr_pend),  32'h0);
        step();
        chk("sel3_c4_e6_tick", 32'(tick), 32'h0);
        step();
        chk("sel3_c4_e7_tick", 32'(tick), 32'h8);
        chk("sel3_c3_e7_tick", 32'(tick3), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
